bus_master_arbiter: RTL
=======================

// Module: bus_master_arbiter
// PURPOSE
//  Registered round-robin arbiter for the shared data-side slave path of sys_bus.
//  Requesters: index 0 = SPI slave, 1 = core DMEM, 2 = DMA; one-hot grant back via req/gnt.
//  Bounded-tenure preemption stops a long DMA transfer from starving the core or SPI.
//  Lock inputs make selected transfers atomic.
// PARAMETERS
//  N_REQ     3   number of requesters (>=2)
//  MAX_HOLD  16  cycles a holder may keep the grant while others wait; 0 = no preemption
//  IDX_W     $clog2(N_REQ)  width of o_gnt_idx
// PORTS
//  i_clk      in   1      system clock
//  i_rst_n    in   1      reset, synchronous, active-low
//  i_req      in   N_REQ  request per master; held high for the whole transfer
//  i_lock     in   N_REQ  holder is not preempted while its lock bit is high
//  o_gnt      out  N_REQ  one-hot grant, registered; all-zero when idle
//  o_gnt_idx  out  IDX_W  index of current holder (valid only when o_busy)
//  o_busy     out  1      |o_gnt
//  o_preempt  out  1      one-cycle pulse on the edge a grant is taken by preemption
// BEHAVIOUR
//  Clock and reset:
//   - One clock (i_clk). Reset i_rst_n is synchronous and active-low.
//   - Reset values: o_gnt=0, o_gnt_idx=0, o_busy=0, o_preempt=0, hold_cnt=0.
//   - Reset sets rr_ptr=0, so index 0 has top priority after reset.
//   - Reset asserted mid-transfer drops the grant on the next edge. No handover.
//  State machine (two states):
//   - IDLE: if any i_req is high, grant the winner on the next edge and go to GRANT.
//     Request at edge N gives o_gnt at N+1, i.e. one cycle of latency.
//   - GRANT, holder still requesting:
//     - Grant kept. hold_cnt increments while other requests are pending.
//     - hold_cnt resets to 0 while no other request is pending.
//   - GRANT, holder drops i_req:
//     - If another requester is pending, the next edge hands over directly with zero bubble.
//     - Otherwise o_gnt=0 and the FSM returns to IDLE.
//   - Preemption occurs when all of these hold:
//     - MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1;
//     - another request is pending;
//     - i_lock[holder] is low.
//     On the next edge the grant moves to the round-robin winner, o_preempt pulses, and hold_cnt=0.
//     The preempted master sees its gnt fall while req is still high. It must stall and keep req high.
//   - If i_lock[holder] is high, hold_cnt saturates at MAX_HOLD-1.
//     Preemption fires on the first cycle lock falls, if others are still pending.
//  Winner selection:
//   - The scan starts at rr_ptr and wraps modulo N_REQ.
//   - The first i_req=1 wins. When re-arbitrating from GRANT, the current holder is excluded.
//   - On every new grant to index k, rr_ptr <= (k+1) mod N_REQ, wrapping N_REQ-1 -> 0.
//  Invariants:
//   - o_gnt is always zero or one-hot.
//   - The grant never changes on an edge where the holder's req is high, unless preemption fires.
//   - A request that is held is granted within (N_REQ-1)*MAX_HOLD + N_REQ cycles when no locks are held.
//   - Simultaneous requests from IDLE are resolved by rr_ptr alone.
//   - i_lock of a non-holder is ignored.
// TESTING
//  1. Reset; req=3'b001 at cycle 0 -> gnt=001 at cycle 1, busy=1.
//     Drop req -> gnt=000 next cycle.
//  2. After reset, req=3'b111 all held for 1 cycle each and then dropped.
//     Grant order: 0,1,2, back-to-back with no idle cycle between handovers.
//  3. MAX_HOLD=16: DMA (idx 2) holds req; core raises req at cycle 5.
//     DMA loses gnt exactly 16 cycles after core's req is seen. Core gnt on that edge, preempt=1 for one cycle.
//  4. Same as 3 with i_lock[2]=1 for 40 cycles -> no preemption.
//     Core granted the cycle after lock falls.
//  5. MAX_HOLD=0: DMA holds 100 cycles with core pending -> no preemption.
//     Core granted the cycle after DMA drops req.
//  6. Assert i_rst_n=0 mid-grant -> all outputs 0 next edge.
//     After release, rr_ptr=0: with req=110, idx 1 wins. Random-traffic check for one-hot and starvation bound.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// Registered round-robin arbiter for the shared data-side slave path, with
// bounded-tenure preemption of the holder and per-master lock to keep transfers atomic.
module bus_master_arbiter #(
    parameter int N_REQ    = 3,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_lock,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_busy,
    output logic             o_preempt
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state_reg,   state_next;
    logic [N_REQ-1:0] gnt_reg,     gnt_next;
    logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic [IDX_W-1:0] rr_ptr_reg,  rr_ptr_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             preempt_reg, preempt_next;

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] rot_req;
    logic [IDX_W-1:0] rot_idx [N_REQ];
    logic             others_pending;
    logic             holder_req;
    logic             holder_lock;
    logic             preempt_fire;
    logic             win_any;
    logic [IDX_W-1:0] win_idx;
    logic             take_new;

    // The current holder never competes when re-arbitrating from GRANT.
    assign arb_req        = i_req & ~gnt_reg;
    assign others_pending = |arb_req;
    assign holder_req     = |(i_req & gnt_reg);
    assign holder_lock    = |(i_lock & gnt_reg);
    assign preempt_fire   = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST)
                            && others_pending && !holder_lock;

    // Rotate the request vector so that offset 0 is the round-robin pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            assign sum         = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
            assign rot_idx[gi] = (sum >= (IDX_W+1)'(N_REQ)) ?
                                 IDX_W'(sum - (IDX_W+1)'(N_REQ)) : sum[IDX_W-1:0];
            assign rot_req[gi] = arb_req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int o = N_REQ - 1; o >= 0; o--) begin
            if (rot_req[o]) begin
                win_any = 1'b1;
                win_idx = rot_idx[o];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_idx_next  = gnt_idx_reg;
        rr_ptr_next   = rr_ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        preempt_next  = 1'b0;
        take_new      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (win_any) begin
                    take_new   = 1'b1;
                    state_next = ST_GRANT;
                end
            end
            default: begin
                if (!holder_req) begin
                    if (others_pending) begin
                        take_new = 1'b1;
                    end else begin
                        gnt_next      = '0;
                        hold_cnt_next = '0;
                        state_next    = ST_IDLE;
                    end
                end else if (preempt_fire) begin
                    take_new     = 1'b1;
                    preempt_next = 1'b1;
                end else if (!others_pending) begin
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg != HOLD_LAST) begin
                    // Saturates at HOLD_LAST when the holder is locked.
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
        endcase

        if (take_new) begin
            gnt_next      = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            gnt_idx_next  = win_idx;
            hold_cnt_next = '0;
            rr_ptr_next   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            gnt_idx_reg  <= '0;
            rr_ptr_reg   <= '0;
            hold_cnt_reg <= '0;
            preempt_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_idx_reg  <= gnt_idx_next;
            rr_ptr_reg   <= rr_ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            preempt_reg  <= preempt_next;
        end
    end

    assign o_gnt     = gnt_reg;
    assign o_gnt_idx = gnt_idx_reg;
    assign o_busy    = |gnt_reg;
    assign o_preempt = preempt_reg;

endmodule
